// File: rtl/router_pkt_fifo.sv
// -----------------------------------------------------------------------------
// router_pkt_fifo
// Packet-aware synchronous FIFO for one router output channel. Each entry holds
// a data word plus a first-of-packet flag. On the read side the block tracks
// how many words of the current packet remain and pulses pkt_done while the
// packet's final (parity) word is on data_out.
//
// Ports
//   clock          rising-edge clock
//   resetn         synchronous active-low reset (highest priority)
//   soft_reset     synchronous active-high flush; requests in that cycle ignored
//   write_enb      write request, data_in/lfd_state stored when accepted
//   read_enb       read request, data_out updated one edge later when accepted
//   lfd_state      marks data_in as a packet header
//   data_in        write data, header = {payload_len, addr[1:0]}
//   data_out       registered read data
//   full/empty     occupancy == DEPTH / occupancy == 0
//   almost_full    occupancy >= AF_THRESH
//   occupancy      number of stored words
//   pkt_done       high while the last word of a packet is on data_out
//   overflow_err   sticky: write attempted while full (no read accepted)
//   underflow_err  sticky: read attempted while empty
// -----------------------------------------------------------------------------
module router_pkt_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = 14
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     soft_reset,
   input  logic                     write_enb,
   input  logic                     read_enb,
   input  logic                     lfd_state,
   input  logic [DATA_WIDTH-1:0]    data_in,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     pkt_done,
   output logic                     overflow_err,
   output logic                     underflow_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = DATA_WIDTH - 1;

   localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   OCC_AF   = (AW+1)'(AF_THRESH);
   localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   OCC_ZERO = (AW+1)'(0);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW-1:0] PTR_ZERO = AW'(0);
   localparam logic [LW-1:0] REM_ONE  = LW'(1);
   localparam logic [LW-1:0] REM_ZERO = LW'(0);

   logic [DATA_WIDTH:0]   mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           occ_q, occ_d;
   logic [LW-1:0]         rem_q, rem_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  pkt_done_q, pkt_done_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;

   logic                  flush_s;
   logic                  rd_acc_s;
   logic                  wr_acc_s;
   logic [DATA_WIDTH:0]   rd_word_s;

   assign full        = (occ_q == OCC_FULL);
   assign empty       = (occ_q == OCC_ZERO);
   assign almost_full = (occ_q >= OCC_AF);
   assign occupancy   = occ_q;
   assign data_out    = dout_q;
   assign pkt_done    = pkt_done_q;
   assign overflow_err  = ovf_q;
   assign underflow_err = udf_q;

   assign flush_s   = ~resetn | soft_reset;
   assign rd_word_s = mem_q[rd_ptr_q];
   assign rd_acc_s  = read_enb & ~empty;
   // A write into a full FIFO is legal when the same cycle frees a slot.
   assign wr_acc_s  = write_enb & (~full | rd_acc_s);

   // Next-state logic for pointers, occupancy, packet tracking, output and flags
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      rem_d      = rem_q;
      dout_d     = dout_q;
      pkt_done_d = 1'b0;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      if (flush_s) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
         occ_d    = OCC_ZERO;
         rem_d    = REM_ZERO;
         dout_d   = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end

         if (write_enb && !wr_acc_s) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_q;
         end

         if (read_enb && !rd_acc_s) begin
            udf_d = 1'b1;
         end else begin
            udf_d = udf_q;
         end

         case ({wr_acc_s, rd_acc_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
         endcase

         if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = rd_word_s[DATA_WIDTH-1:0];
            if (rd_word_s[DATA_WIDTH]) begin
               // Header: payload words plus the trailing parity word.
               rem_d = {1'b0, rd_word_s[DATA_WIDTH-1:2]} + REM_ONE;
            end else if (rem_q != REM_ZERO) begin
               rem_d      = rem_q - REM_ONE;
               pkt_done_d = (rem_q == REM_ONE);
            end else begin
               // Orphan data outside any packet: no tracking change.
               rem_d = rem_q;
            end
         end else if (pkt_done_q) begin
            // Return the output to zero once the parity word has been shown.
            dout_d = '0;
         end else begin
            dout_d = dout_q;
         end
      end
   end

   // State registers with synchronous active-low reset folded into flush_s
   always_ff @(posedge clock) begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      rem_q      <= rem_d;
      dout_q     <= dout_d;
      pkt_done_q <= pkt_done_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
   end

   // Storage array; contents are not cleared, pointers make stale data unreachable
   always_ff @(posedge clock) begin
      if (!flush_s && wr_acc_s) begin
         mem_q[wr_ptr_q] <= {lfd_state, data_in};
      end
   end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// -----------------------------------------------------------------------------
// Bench for router_pkt_fifo. Two instances: default parameters (A) and
// DATA_WIDTH=16, DEPTH=8, AF_THRESH=6 (B). A circular-array model of the FIFO
// predicts every output each cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_router_pkt_fifo;

   logic        clk;
   logic        resetn;
   logic        soft_reset;
   logic        we  [2];
   logic        re  [2];
   logic        lfd [2];
   logic [15:0] din [2];

   logic [7:0]  dout_a;
   logic        full_a, empty_a, af_a, pd_a, ovf_a, udf_a;
   logic [4:0]  occ_a;
   logic [15:0] dout_b;
   logic        full_b, empty_b, af_b, pd_b, ovf_b, udf_b;
   logic [3:0]  occ_b;

   int n_checks = 0;
   int n_errs   = 0;
   int pd_cnt_b = 0;

   // model state
   int m_d    [2][16];
   bit m_f    [2][16];
   int m_head [2];
   int m_cnt  [2];
   int m_dout [2];
   int m_rem  [2];
   bit m_pd   [2];
   bit m_ovf  [2];
   bit m_udf  [2];
   int DEP [2] = '{16, 8};
   int AFT [2] = '{14, 6};
   int DWV [2] = '{8, 16};

   router_pkt_fifo u_a (
      .clock(clk), .resetn(resetn), .soft_reset(soft_reset),
      .write_enb(we[0]), .read_enb(re[0]), .lfd_state(lfd[0]),
      .data_in(din[0][7:0]), .data_out(dout_a),
      .full(full_a), .empty(empty_a), .almost_full(af_a), .occupancy(occ_a),
      .pkt_done(pd_a), .overflow_err(ovf_a), .underflow_err(udf_a)
   );

   router_pkt_fifo #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6)) u_b (
      .clock(clk), .resetn(resetn), .soft_reset(soft_reset),
      .write_enb(we[1]), .read_enb(re[1]), .lfd_state(lfd[1]),
      .data_in(din[1]), .data_out(dout_b),
      .full(full_b), .empty(empty_b), .almost_full(af_b), .occupancy(occ_b),
      .pkt_done(pd_b), .overflow_err(ovf_b), .underflow_err(udf_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply the FIFO rules to the inputs that the coming rising edge will sample.
   task automatic model_update();
      for (int i = 0; i < 2; i++) begin
         if (!resetn || soft_reset) begin
            m_head[i] = 0; m_cnt[i] = 0; m_dout[i] = 0; m_rem[i] = 0;
            m_pd[i] = 1'b0; m_ovf[i] = 1'b0; m_udf[i] = 1'b0;
         end else begin
            bit rd_ok, wr_ok, was_pd;
            int mask, tail;
            mask   = (1 << DWV[i]) - 1;
            rd_ok  = re[i] && (m_cnt[i] > 0);
            wr_ok  = we[i] && ((m_cnt[i] < DEP[i]) || rd_ok);
            was_pd = m_pd[i];
            m_pd[i] = 1'b0;
            if (rd_ok) begin
               m_dout[i] = m_d[i][m_head[i]];
               if (m_f[i][m_head[i]]) begin
                  m_rem[i] = (m_dout[i] >> 2) + 1;
               end else if (m_rem[i] > 0) begin
                  m_rem[i] = m_rem[i] - 1;
                  if (m_rem[i] == 0) m_pd[i] = 1'b1;
               end
               m_head[i] = (m_head[i] + 1) % DEP[i];
               m_cnt[i]  = m_cnt[i] - 1;
            end else if (was_pd) begin
               m_dout[i] = 0;
            end
            if (re[i] && !rd_ok) m_udf[i] = 1'b1;
            if (we[i] && !wr_ok) m_ovf[i] = 1'b1;
            if (wr_ok) begin
               tail = (m_head[i] + m_cnt[i]) % DEP[i];
               m_d[i][tail] = int'(din[i]) & mask;
               m_f[i][tail] = lfd[i];
               m_cnt[i] = m_cnt[i] + 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("A.data_out",    32'(dout_a), 32'(m_dout[0]));
      chk("A.pkt_done",    32'(pd_a),   32'(m_pd[0]));
      chk("A.occupancy",   32'(occ_a),  32'(m_cnt[0]));
      chk("A.full",        32'(full_a), 32'(m_cnt[0] == DEP[0]));
      chk("A.empty",       32'(empty_a), 32'(m_cnt[0] == 0));
      chk("A.almost_full", 32'(af_a),   32'(m_cnt[0] >= AFT[0]));
      chk("A.overflow",    32'(ovf_a),  32'(m_ovf[0]));
      chk("A.underflow",   32'(udf_a),  32'(m_udf[0]));
      chk("B.data_out",    32'(dout_b), 32'(m_dout[1]));
      chk("B.pkt_done",    32'(pd_b),   32'(m_pd[1]));
      chk("B.occupancy",   32'(occ_b),  32'(m_cnt[1]));
      chk("B.full",        32'(full_b), 32'(m_cnt[1] == DEP[1]));
      chk("B.empty",       32'(empty_b), 32'(m_cnt[1] == 0));
      chk("B.almost_full", 32'(af_b),   32'(m_cnt[1] >= AFT[1]));
      chk("B.overflow",    32'(ovf_b),  32'(m_ovf[1]));
      chk("B.underflow",   32'(udf_b),  32'(m_udf[1]));
   endtask

   task automatic step();
      model_update();
      @(negedge clk);
      compare_all();
      if (pd_b) pd_cnt_b++;
   endtask

   task automatic set_in(input int i, input bit w, input bit r, input bit l, input int d);
      we[i]  = w;
      re[i]  = r;
      lfd[i] = l;
      din[i] = d[15:0];
   endtask

   task automatic idle_all();
      set_in(0, 1'b0, 1'b0, 1'b0, 0);
      set_in(1, 1'b0, 1'b0, 1'b0, 0);
   endtask

   initial begin
      int snap, k;
      resetn = 1'b0;
      soft_reset = 1'b0;
      idle_all();
      step();
      step();
      resetn = 1'b1;
      chk("A.rst_occ",   32'(occ_a),   32'd0);
      chk("A.rst_empty", 32'(empty_a), 32'd1);
      chk("A.rst_full",  32'(full_a),  32'd0);
      chk("A.rst_af",    32'(af_a),    32'd0);
      chk("A.rst_dout",  32'(dout_a),  32'd0);

      // header 0x39 (len 14) + 14 payload + parity fills the FIFO
      set_in(0, 1'b1, 1'b0, 1'b1, 32'h39);
      step();
      for (int j = 0; j < 14; j++) begin
         set_in(0, 1'b1, 1'b0, 1'b0, 32'h10 + j);
         step();
         if (j == 11) chk("A.af_at13", 32'(af_a), 32'd0);
         if (j == 12) chk("A.af_at14", 32'(af_a), 32'd1);
      end
      set_in(0, 1'b1, 1'b0, 1'b0, 32'hEE);
      step();
      chk("A.occ_full", 32'(occ_a),  32'd16);
      chk("A.full",     32'(full_a), 32'd1);

      // 17th write while full
      set_in(0, 1'b1, 1'b0, 1'b0, 32'h77);
      step();
      chk("A.ovf_occ", 32'(occ_a), 32'd16);
      chk("A.ovf_err", 32'(ovf_a), 32'd1);

      // drain the packet back-to-back
      for (int j = 0; j < 16; j++) begin
         set_in(0, 1'b0, 1'b1, 1'b0, 0);
         step();
         if (j == 0)  chk("A.first_hdr", 32'(dout_a), 32'h39);
         if (j == 14) chk("A.pd_early",  32'(pd_a),   32'd0);
         if (j == 15) begin
            chk("A.parity_out", 32'(dout_a), 32'hEE);
            chk("A.parity_pd",  32'(pd_a),   32'd1);
         end
      end
      set_in(0, 1'b0, 1'b0, 1'b0, 0);
      step();
      chk("A.idle_zero",  32'(dout_a),  32'd0);
      chk("A.idle_empty", 32'(empty_a), 32'd1);

      // refill, then simultaneous read+write while full
      for (int j = 0; j < 16; j++) begin
         set_in(0, 1'b1, 1'b0, 1'b0, 32'h60 + j);
         step();
      end
      set_in(0, 1'b1, 1'b1, 1'b0, 32'h55);
      step();
      chk("A.rw_occ",  32'(occ_a),  32'd16);
      chk("A.rw_dout", 32'(dout_a), 32'h60);
      for (int j = 0; j < 16; j++) begin
         set_in(0, 1'b0, 1'b1, 1'b0, 0);
         step();
      end
      chk("A.rw_last", 32'(dout_a), 32'h55);

      // underflow holds data_out
      set_in(0, 1'b0, 1'b1, 1'b0, 0);
      step();
      chk("A.udf_err",  32'(udf_a),  32'd1);
      chk("A.udf_hold", 32'(dout_a), 32'h55);

      // partial packet, then soft reset with requests present
      set_in(0, 1'b1, 1'b0, 1'b1, 32'h20);
      step();
      for (int j = 0; j < 6; j++) begin
         set_in(0, 1'b1, 1'b0, 1'b0, 32'h30 + j);
         step();
      end
      chk("A.occ7", 32'(occ_a), 32'd7);
      soft_reset = 1'b1;
      set_in(0, 1'b1, 1'b1, 1'b1, 32'h12);
      step();
      soft_reset = 1'b0;
      chk("A.sr_occ",  32'(occ_a),  32'd0);
      chk("A.sr_ovf",  32'(ovf_a),  32'd0);
      chk("A.sr_udf",  32'(udf_a),  32'd0);
      chk("A.sr_dout", 32'(dout_a), 32'd0);

      // zero-length header followed by parity
      set_in(0, 1'b1, 1'b0, 1'b1, 32'h00);
      step();
      set_in(0, 1'b1, 1'b0, 1'b0, 32'hA5);
      step();
      set_in(0, 1'b0, 1'b1, 1'b0, 0);
      step();
      chk("A.len0_hdr_pd", 32'(pd_a), 32'd0);
      step();
      chk("A.len0_dout", 32'(dout_a), 32'hA5);
      chk("A.len0_pd",   32'(pd_a),   32'd1);
      set_in(0, 1'b0, 1'b0, 1'b0, 0);
      step();
      chk("A.len0_zero", 32'(dout_a), 32'd0);

      // instance B: len-100 packet over repeated fill/drain with wrap-around
      snap = pd_cnt_b;
      k = 0;
      while (k < 102) begin
         int n;
         n = 0;
         while (n < 8 && k < 102) begin
            int w;
            w = (k == 0) ? 32'h192 : ((k == 101) ? 32'hBEEF : 32'h1000 + k);
            set_in(1, 1'b1, 1'b0, (k == 0), w);
            step();
            n++;
            k++;
            if (n == 5) chk("B.af_at5", 32'(af_b), 32'd0);
            if (n == 6) chk("B.af_at6", 32'(af_b), 32'd1);
         end
         if (n == 8) chk("B.full_at8", 32'(full_b), 32'd1);
         for (int j = 0; j < n; j++) begin
            set_in(1, 1'b0, 1'b1, 1'b0, 0);
            step();
         end
         set_in(1, 1'b0, 1'b0, 1'b0, 0);
         step();
      end
      chk("B.pd_once", 32'(pd_cnt_b - snap), 32'd1);

      // randomized traffic on both instances
      for (int c = 0; c < 4000; c++) begin
         int ph;
         ph = (c / 400) % 3;
         soft_reset = ($urandom_range(0, 249) == 0);
         resetn     = ($urandom_range(0, 999) != 0);
         for (int i = 0; i < 2; i++) begin
            bit w, r;
            if (ph == 0) begin
               w = ($urandom_range(0, 3) != 0);
               r = ($urandom_range(0, 3) == 0);
            end else if (ph == 1) begin
               w = ($urandom_range(0, 3) == 0);
               r = ($urandom_range(0, 3) != 0);
            end else begin
               w = $urandom_range(0, 1) != 0;
               r = $urandom_range(0, 1) != 0;
            end
            set_in(i, w, r, ($urandom_range(0, 7) == 0), int'($urandom));
         end
         step();
      end
      resetn = 1'b1;
      soft_reset = 1'b0;
      idle_all();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
- Parametrised, packet-aware synchronous FIFO for the router's per-destination output channels.
- Stores each data word together with a first-of-packet flag.
- Tracks how many words of the current packet are left to read, and signals when the packet's final (parity) word appears on the output.
- Adds occupancy, almost-full and sticky error reporting, so the sync/FSM blocks can throttle and diagnose traffic.

Parameters:
- DATA_WIDTH, 8: word width; header layout is {payload_len[DATA_WIDTH-1:2], addr[1:0]}.
- DEPTH, 16: number of entries; must be a power of 2 and at least 4.
- AF_THRESH, 14: occupancy at or above which almost_full asserts; legal range 1..DEPTH.
- Derived, not overridable: AW = log2(DEPTH); LW = DATA_WIDTH-1 (width of the remaining-word counter).

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset
- soft_reset  in  1  synchronous active-high flush (timeout from the sync block)
- write_enb  in  1  write request
- read_enb  in  1  read request
- lfd_state  in  1  marks the current data_in as a packet header
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  registered read data
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- almost_full  out  1  occupancy >= AF_THRESH
- occupancy  out  AW+1  number of stored words
- pkt_done  out  1  one-cycle pulse while the last word of a packet is on data_out
- overflow_err  out  1  sticky: a write was attempted while full
- underflow_err  out  1  sticky: a read was attempted while empty

Behaviour:

Storage
- Memory of DEPTH x (DATA_WIDTH+1); bit DATA_WIDTH holds the lfd_state value sampled with the write.
- Pointers are AW bits and wrap naturally at DEPTH.

Reset and flush
- resetn=0 (has priority): pointers, occupancy, rem_cnt, data_out, pkt_done, overflow_err and underflow_err are all cleared to 0.
- soft_reset=1 (resetn=1): clears the same state as resetn; write and read requests in that cycle are ignored.
- Memory contents are not cleared by either; they are unreachable once the pointers reset.
- After reset: empty=1, full=0, almost_full=0.

Write (write_enb=1)
- Accepted when !full, or when full and a read is accepted in the same cycle.
- Stores {lfd_state, data_in} at wr_ptr, then increments wr_ptr.
- Write while full without an accepted read: ignored, overflow_err<=1.

Read (read_enb=1)
- Accepted when !empty.
- data_out <= mem[rd_ptr] data field on the next rising edge (1-cycle latency); rd_ptr increments.
- Read while empty: ignored, data_out holds, underflow_err<=1.
- No write-to-read bypass: a simultaneous read and write while empty performs the write only and sets underflow_err.

Occupancy
- +1 on an accepted write alone, -1 on an accepted read alone, unchanged when both are accepted.
- full, empty and almost_full are combinational decodes of the occupancy register.

Packet tracking (rem_cnt, LW bits)
- Accepted read of a flagged word: rem_cnt <= header[DATA_WIDTH-1:2] + 1 (payload plus parity).
- Accepted read of an unflagged word with rem_cnt>0: rem_cnt <= rem_cnt-1.
- Unflagged word read with rem_cnt==0: rem_cnt stays 0 and no pulse is generated (orphan data).
- pkt_done <= 1 on the edge where rem_cnt goes from 1 to 0; otherwise pkt_done <= 0. It is therefore coincident with the parity word on data_out.
- A header with payload_len=0 loads rem_cnt=1; the next read (parity) fires pkt_done.
- A flagged word read while rem_cnt>0 reloads the counter; the truncated packet gets no pkt_done.

Data output
- data_out holds its last value between reads.
- Idle behaviour: data_out <= 0 on the cycle after pkt_done when no read is accepted. This replaces high-impedance output.

Errors
- overflow_err and underflow_err are cleared only by resetn or soft_reset.

Test Plan:
- Reset, then write a header 0x39 (len 14, addr 01) with lfd_state=1, 14 payload words, and 1 parity word -> occupancy=16, full=1, almost_full=1 from occupancy 14.
- Read 16 words back-to-back -> data_out matches write order with 1-cycle latency; pkt_done is high exactly on the parity cycle; data_out=0 the following cycle; empty=1.
- With the FIFO full, a 17th write with no read -> data ignored, occupancy stays 16, overflow_err=1; a simultaneous read+write while full -> occupancy stays 16, and the new word is read last.
- Read while empty -> underflow_err=1, data_out unchanged; then soft_reset for 1 cycle mid-packet (occupancy 7) -> occupancy=0, rem_cnt=0, both error flags cleared, data_out=0.
- Header 0x00 (len 0) followed by parity 0xA5 -> pkt_done pulses while data_out=0xA5.
- Override parameters DATA_WIDTH=16, DEPTH=8, AF_THRESH=6 -> full at 8, almost_full at 6; a header with len 100 counts down 101 reads across multiple fill/drain cycles with wrap-around, and pkt_done fires exactly once.
